// File: rtl/clint_timer_src_if.sv
// Register-port bundle between the uncore bus bridge (master) and the CLINT timer source (slave).
// Req/Write/Adr/WData flow toward the slave; RData/Err are qualified by the one-cycle Ack pulse.
interface clint_timer_src_if #(
  parameter int XLEN = 64
);
  logic            Req;
  logic            Write;
  logic [15:0]     Adr;
  logic [XLEN-1:0] WData;
  logic [XLEN-1:0] RData;
  logic            Ack;
  logic            Err;

  modport master (output Req, Write, Adr, WData, input RData, Ack, Err);
  modport slave  (input Req, Write, Adr, WData, output RData, Ack, Err);
endinterface

// File: rtl/clint_timer_src.sv
// CLINT interrupt source for one hart: mtime, mtimecmp and msip behind a Req/Ack register port.
// Optional mtime prescaler is enabled by defining WALLY_CLINT_PRESCALE_EN.
module clint_timer_src #(
  parameter int XLEN     = 64,
  parameter int PRESCALE = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  clint_timer_src_if.slave        bus,
  output logic [63:0]             MTIME_CLINT,
  output logic                    MTimerInt,
  output logic                    MSwInt
);
  typedef enum logic {IDLE, ACK} state_t;

  localparam bit IS32 = (XLEN == 32);

  if ((PRESCALE < 1) || ((XLEN != 32) && (XLEN != 64))) begin : g_bad_param
    $error("clint_timer_src: XLEN must be 32 or 64 and PRESCALE must be >= 1");
  end

  state_t          r_state;
  logic [63:0]     r_mtime;
  logic [63:0]     r_mtimecmp;
  logic            r_msip;
  logic            r_mtint;
  logic            r_ack;
  logic            r_err;
  logic [XLEN-1:0] r_rdata;

  logic [63:0]     w_wdata;
  logic [31:0]     w_wdata_hi;
  logic [63:0]     w_rdata;
  logic            w_access;
  logic            w_wr;
  logic            w_sel_msip;
  logic            w_sel_cmp_lo;
  logic            w_sel_cmp_hi;
  logic            w_sel_time_lo;
  logic            w_sel_time_hi;
  logic            w_mapped;
  logic            w_cmp_wr_lo;
  logic            w_cmp_wr_hi;
  logic            w_time_wr_lo;
  logic            w_time_wr_hi;
  logic            w_time_wr;
  logic            w_tick;

  // With XLEN=64 the single low address covers both halves; the upper data word feeds the high half.
  assign w_wdata      = 64'(bus.WData);
  assign w_wdata_hi   = IS32 ? w_wdata[31:0] : w_wdata[63:32];

  assign w_access     = (r_state == IDLE) && bus.Req;
  assign w_wr         = w_access && bus.Write;

  assign w_sel_msip    = (bus.Adr == 16'h0000);
  assign w_sel_cmp_lo  = (bus.Adr == 16'h4000);
  assign w_sel_cmp_hi  = IS32 && (bus.Adr == 16'h4004);
  assign w_sel_time_lo = (bus.Adr == 16'hBFF8);
  assign w_sel_time_hi = IS32 && (bus.Adr == 16'hBFFC);
  assign w_mapped      = w_sel_msip | w_sel_cmp_lo | w_sel_cmp_hi | w_sel_time_lo | w_sel_time_hi;

  assign w_cmp_wr_lo  = w_wr && w_sel_cmp_lo;
  assign w_cmp_wr_hi  = w_wr && (IS32 ? w_sel_cmp_hi : w_sel_cmp_lo);
  assign w_time_wr_lo = w_wr && w_sel_time_lo;
  assign w_time_wr_hi = w_wr && (IS32 ? w_sel_time_hi : w_sel_time_lo);
  assign w_time_wr    = w_time_wr_lo || w_time_wr_hi;

  always_comb begin
    w_rdata = '0;
    if (w_sel_msip)         w_rdata = {63'd0, r_msip};
    else if (w_sel_cmp_lo)  w_rdata = IS32 ? {32'd0, r_mtimecmp[31:0]} : r_mtimecmp;
    else if (w_sel_cmp_hi)  w_rdata = {32'd0, r_mtimecmp[63:32]};
    else if (w_sel_time_lo) w_rdata = IS32 ? {32'd0, r_mtime[31:0]} : r_mtime;
    else if (w_sel_time_hi) w_rdata = {32'd0, r_mtime[63:32]};
  end

`ifdef WALLY_CLINT_PRESCALE_EN
  localparam int              DIVW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(PRESCALE - 1);

  logic [DIVW-1:0] r_div;

  assign w_tick = (r_div == DIV_LAST);

  // Any mtime write restarts the divider so the next tick lands a full period later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   r_div <= '0;
    else if (w_time_wr || w_tick) r_div <= '0;
    else                         r_div <= r_div + DIVW'(1);
  end
`else
  assign w_tick = 1'b1;
`endif

  // A bus write beats the tick; the half that is not written keeps its value with no carry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mtime <= '0;
    end else if (w_time_wr) begin
      if (w_time_wr_lo) r_mtime[31:0]  <= w_wdata[31:0];
      if (w_time_wr_hi) r_mtime[63:32] <= w_wdata_hi;
    end else if (w_tick) begin
      r_mtime <= r_mtime + 64'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mtimecmp <= '1;
      r_msip     <= 1'b0;
      r_mtint    <= 1'b0;
    end else begin
      if (w_cmp_wr_lo)           r_mtimecmp[31:0]  <= w_wdata[31:0];
      if (w_cmp_wr_hi)           r_mtimecmp[63:32] <= w_wdata_hi;
      if (w_wr && w_sel_msip)    r_msip            <= w_wdata[0];
      r_mtint <= (r_mtime >= r_mtimecmp);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.Req) begin
            r_state <= ACK;
            r_ack   <= 1'b1;
            r_err   <= !w_mapped;
            r_rdata <= (w_mapped && !bus.Write) ? w_rdata[XLEN-1:0] : '0;
          end
        end
        ACK: begin
          r_state <= IDLE;
          r_ack   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.RData   = r_rdata;
  assign bus.Ack     = r_ack;
  assign bus.Err     = r_err;
  assign MTIME_CLINT = r_mtime;
  assign MTimerInt   = r_mtint;
  assign MSwInt      = r_msip;
endmodule
